// File: rtl/relay_pkg.sv
// Shared types and constants for the relay bank controller.
package relay_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_PEND_ON = 2'd1,
    ST_ON_HOLD = 2'd2,
    ST_ON      = 2'd3
  } relay_state_e;

  localparam logic MODE_FOLLOW = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  localparam logic LVL_LOW  = 1'b0;
  localparam logic LVL_HIGH = 1'b1;

  function automatic logic relay_is_on(input relay_state_e s);
    return (s == ST_ON_HOLD) || (s == ST_ON);
  endfunction

endpackage

// File: rtl/relay_debounce.sv
// One channel: 2-flop synchroniser followed by a stable-count debouncer.
module relay_debounce
  import relay_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic Clk_i,
  input  logic Reset_i,
  input  logic Switch_i,
  output logic Level_o,
  output logic Rise_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             settle;

  // The level updates on the edge that would make the count reach DEBOUNCE_CYCLES.
  assign settle = (s2_q != db_q) && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (settle) begin
      cnt_d = '0;
      db_d  = s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      s1_q  <= LVL_LOW;
      s2_q  <= LVL_LOW;
      db_q  <= LVL_LOW;
      cnt_q <= '0;
    end else begin
      s1_q  <= Switch_i;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign Level_o = db_q;
  assign Rise_o  = settle && (s2_q == LVL_HIGH);

endmodule

// File: rtl/relay_bank_ctrl.sv
// Multi-channel relay driver: debounced requests, per-channel hold FSM and a
// shared stagger scheduler that spaces relay turn-ons.
module relay_bank_ctrl
  import relay_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned MIN_HOLD_CYCLES = 100000,
  parameter int unsigned STAGGER_CYCLES  = 20000,
  parameter bit          ACTIVE_LOW_OUT  = 1'b0
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  input  logic [NUM_CH-1:0] Switch_i,
  input  logic [NUM_CH-1:0] Mode_i,
  input  logic              Enable_i,
  output logic [NUM_CH-1:0] Relay_o,
  output logic              Busy_o
);

  localparam int unsigned HOLD_W = (MIN_HOLD_CYCLES > 1) ? $clog2(MIN_HOLD_CYCLES) : 1;
  localparam int unsigned STAG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD_CYCLES - 1);
  localparam logic [STAG_W-1:0] STAG_LOAD = STAG_W'(STAGGER_CYCLES - 1);

  logic [NUM_CH-1:0] db, db_rise, req;
  logic [NUM_CH-1:0] mode_q;
  logic [NUM_CH-1:0] tog_q, tog_d;
  logic [NUM_CH-1:0] grant, pend;
  logic [NUM_CH-1:0] relay_q, relay_d;
  logic              grant_taken;

  relay_state_e      state_q [NUM_CH];
  relay_state_e      state_d [NUM_CH];
  logic [HOLD_W-1:0] hold_q  [NUM_CH];
  logic [HOLD_W-1:0] hold_d  [NUM_CH];
  logic [STAG_W-1:0] stag_q, stag_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    relay_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .Clk_i   (Clk_i),
      .Reset_i (Reset_i),
      .Switch_i(Switch_i[g]),
      .Level_o (db[g]),
      .Rise_o  (db_rise[g])
    );
  end

  // Toggle flips on the same edge the debounced level rises, so both modes share latency.
  always_comb begin
    tog_d = tog_q;
    req   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!Enable_i) begin
        tog_d[i] = 1'b0;
      end else if ((Mode_i[i] == MODE_TOGGLE) && (mode_q[i] == MODE_FOLLOW)) begin
        tog_d[i] = db[i];
      end else if (db_rise[i]) begin
        tog_d[i] = ~tog_q[i];
      end
      req[i] = (mode_q[i] == MODE_TOGGLE) ? tog_q[i] : db[i];
    end
  end

  always_comb begin
    grant       = '0;
    grant_taken = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!grant_taken && (stag_q == '0) && Enable_i && req[i] &&
          (state_q[i] == ST_PEND_ON)) begin
        grant[i]    = 1'b1;
        grant_taken = 1'b1;
      end
    end
  end

  always_comb begin
    pend    = '0;
    relay_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
      pend[i]    = (state_q[i] == ST_PEND_ON);
      if (!Enable_i) begin
        state_d[i] = ST_OFF;
        hold_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          ST_OFF: begin
            if (req[i]) state_d[i] = ST_PEND_ON;
          end
          ST_PEND_ON: begin
            if (!req[i]) begin
              state_d[i] = ST_OFF;
            end else if (grant[i]) begin
              state_d[i] = ST_ON_HOLD;
              hold_d[i]  = '0;
            end
          end
          ST_ON_HOLD: begin
            if (hold_q[i] == HOLD_LAST) state_d[i] = ST_ON;
            else                        hold_d[i]  = hold_q[i] + 1'b1;
          end
          ST_ON: begin
            if (!req[i]) state_d[i] = ST_OFF;
          end
          default: state_d[i] = ST_OFF;
        endcase
      end
      relay_d[i] = relay_is_on(state_d[i]) ^ ACTIVE_LOW_OUT;
    end
  end

  always_comb begin
    stag_d = stag_q;
    if (|grant)              stag_d = STAG_LOAD;
    else if (stag_q != '0)   stag_d = stag_q - 1'b1;
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      mode_q  <= '0;
      tog_q   <= '0;
      stag_q  <= '0;
      relay_q <= {NUM_CH{ACTIVE_LOW_OUT}};
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_OFF;
        hold_q[i]  <= '0;
      end
    end else begin
      mode_q  <= Mode_i;
      tog_q   <= tog_d;
      stag_q  <= stag_d;
      relay_q <= relay_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
      end
    end
  end

  assign Relay_o = relay_q;
  assign Busy_o  = (|pend) || (stag_q != '0);

endmodule

// File: tb/tb_relay_bank_ctrl.sv
// Directed bench: active-high and active-low instances driven in parallel.
module tb_relay_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] mode;
  logic       en;
  logic [3:0] relay, relay_al;
  logic       busy, busy_al;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  relay_bank_ctrl #(
    .NUM_CH(4), .DEBOUNCE_CYCLES(4), .MIN_HOLD_CYCLES(16), .STAGGER_CYCLES(8),
    .ACTIVE_LOW_OUT(1'b0)
  ) dut (
    .Clk_i(clk), .Reset_i(rst), .Switch_i(sw), .Mode_i(mode), .Enable_i(en),
    .Relay_o(relay), .Busy_o(busy)
  );

  relay_bank_ctrl #(
    .NUM_CH(4), .DEBOUNCE_CYCLES(4), .MIN_HOLD_CYCLES(16), .STAGGER_CYCLES(8),
    .ACTIVE_LOW_OUT(1'b1)
  ) dut_al (
    .Clk_i(clk), .Reset_i(rst), .Switch_i(sw), .Mode_i(mode), .Enable_i(en),
    .Relay_o(relay_al), .Busy_o(busy_al)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    sw   = 4'b0000;
    mode = 4'b0000;
    en   = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    rst  = 1'b1;
    sw   = '0;
    mode = '0;
    en   = 1'b1;
    #2;
    check("rst_relay", relay, 4'b0000);
    check("rst_relay_al", relay_al, 4'b1111);
    check("rst_busy", busy, 1'b0);

    // 1: glitch rejected, then follow-mode on/off latency
    do_reset();
    sw = 4'b0001;
    step(3);
    sw = 4'b0000;
    step(12);
    check("glitch_relay", relay, 4'b0000);
    check("glitch_busy", busy, 1'b0);
    sw = 4'b0001;
    step(7);
    check("t1_pre_relay", relay, 4'b0000);
    check("t1_pre_busy", busy, 1'b1);
    step(1);
    check("t1_on", relay, 4'b0001);
    check("t1_on_al", relay_al, 4'b1110);
    step(30);
    check("t1_idle_busy", busy, 1'b0);
    sw = 4'b0000;
    step(6);
    check("t1_off_pre", relay, 4'b0001);
    step(1);
    check("t1_off", relay, 4'b0000);
    check("t1_off_al", relay_al, 4'b1111);

    // 2: simultaneous requests served STAGGER apart
    do_reset();
    sw = 4'b0101;
    step(7);
    check("t2_pend_busy", busy, 1'b1);
    check("t2_pend_relay", relay, 4'b0000);
    step(1);
    check("t2_T", relay, 4'b0001);
    step(7);
    check("t2_T7", relay, 4'b0001);
    check("t2_T7_busy", busy, 1'b1);
    step(1);
    check("t2_T8", relay, 4'b0101);

    // 3: minimum hold outlasts an early release
    do_reset();
    sw = 4'b0010;
    step(8);
    check("t3_on", relay, 4'b0010);
    step(5);
    sw = 4'b0000;
    step(10);
    check("t3_T15", relay, 4'b0010);
    step(1);
    check("t3_T16", relay, 4'b0010);
    step(1);
    check("t3_T17", relay, 4'b0000);

    // 4: toggle mode on ch3
    do_reset();
    mode = 4'b1000;
    step(2);
    sw = 4'b1000;
    step(8);
    check("t4_press1", relay, 4'b1000);
    step(20);
    sw = 4'b0000;
    step(20);
    check("t4_release1", relay, 4'b1000);
    sw = 4'b1000;
    step(6);
    check("t4_press2_pre", relay, 4'b1000);
    step(1);
    check("t4_press2", relay, 4'b0000);
    sw = 4'b0000;
    step(20);
    check("t4_release2", relay, 4'b0000);

    // 5: enable drop overrides hold and pending, then async reset mid-stagger
    do_reset();
    sw = 4'b0011;
    step(8);
    check("t5_hold", relay, 4'b0001);
    check("t5_busy", busy, 1'b1);
    step(2);
    en = 1'b0;
    step(1);
    check("t5_dis", relay, 4'b0000);
    check("t5_dis_al", relay_al, 4'b1111);
    step(10);
    check("t5_dis_late", relay, 4'b0000);
    check("t5_dis_busy", busy, 1'b0);
    en = 1'b1;
    step(2);
    check("t5_reen", relay, 4'b0001);
    step(3);
    check("t5_stag_busy", busy, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("t5_arst_relay", relay, 4'b0000);
    check("t5_arst_relay_al", relay_al, 4'b1111);
    check("t5_arst_busy", busy, 1'b0);
    step(1);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
